moving_average_window: RTL and testbench

//  Parametrised boxcar moving-average filter: arithmetic mean of the last DEPTH accepted samples.

---
 rtl/moving_average_window.sv | 105 ++++++++++
 tb/tb_moving_average_window.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/moving_average_window.sv
// Boxcar moving-average filter: registered mean of the last DEPTH accepted samples.
// Optional build macro MOVING_AVERAGE_ROUND_EN selects round-half-up instead of truncation.
module moving_average_window #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic [DATA_W-1:0]     avg_out,
  output logic                  out_valid,
  output logic                  filled,
  output logic [LOG2_DEPTH:0]   fill_cnt
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W = DATA_W + LOG2_DEPTH;
  localparam int unsigned CNT_W = LOG2_DEPTH + 1;

  logic [DATA_W-1:0]     win_q [DEPTH];
  logic [DATA_W-1:0]     win_d [DEPTH];
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      fill_q, fill_d;
  logic                  pend_q, pend_d;
  logic [DATA_W-1:0]     avg_q, avg_d;
  logic                  ov_q, ov_d;

  logic                  accept;
  logic                  do_clear;
  logic [DATA_W-1:0]     avg_calc;

  assign accept   = ena & in_valid & ~clear;
  assign do_clear = ena & clear;

  // Mean of the running sum; divisor is always DEPTH
`ifdef MOVING_AVERAGE_ROUND_EN
  logic [SUM_W:0] round_sum;
  assign round_sum = {1'b0, sum_q} + (SUM_W+1)'(DEPTH / 2);
  assign avg_calc  = DATA_W'(round_sum >> LOG2_DEPTH);
`else
  assign avg_calc  = DATA_W'(sum_q >> LOG2_DEPTH);
`endif

  // Next-state: window update on accept, flush on clear, output stage one edge behind
  always_comb begin
    win_d  = win_q;
    sum_d  = sum_q;
    ptr_d  = ptr_q;
    fill_d = fill_q;
    pend_d = 1'b0;
    avg_d  = avg_q;
    ov_d   = 1'b0;

    // Output stage completes for a sample accepted last edge unless flushed
    if (pend_q && !do_clear) begin
      avg_d = avg_calc;
      ov_d  = 1'b1;
    end

    if (do_clear) begin
      for (int i = 0; i < int'(DEPTH); i++) win_d[i] = '0;
      sum_d  = '0;
      ptr_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      // Sum always covers the evicted entry, so subtraction cannot underflow
      sum_d        = sum_q + SUM_W'(in_data) - SUM_W'(win_q[ptr_q]);
      win_d[ptr_q] = in_data;
      ptr_d        = ptr_q + LOG2_DEPTH'(1);
      if (fill_q != CNT_W'(DEPTH)) fill_d = fill_q + CNT_W'(1);
      pend_d       = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) win_q[i] <= '0;
      sum_q  <= '0;
      ptr_q  <= '0;
      fill_q <= '0;
      pend_q <= 1'b0;
      avg_q  <= '0;
      ov_q   <= 1'b0;
    end else begin
      win_q  <= win_d;
      sum_q  <= sum_d;
      ptr_q  <= ptr_d;
      fill_q <= fill_d;
      pend_q <= pend_d;
      avg_q  <= avg_d;
      ov_q   <= ov_d;
    end
  end

  assign avg_out   = avg_q;
  assign out_valid = ov_q;
  assign fill_cnt  = fill_q;
  assign filled    = (fill_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_moving_average_window.sv
// Directed self-checking bench for moving_average_window (DATA_W=8, LOG2_DEPTH=2).
module tb_moving_average_window;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] avg_out;
  logic       out_valid;
  logic       filled;
  logic [2:0] fill_cnt;

  int checks = 0;
  int errors = 0;

  moving_average_window #(.DATA_W(8), .LOG2_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .avg_out   (avg_out),
    .out_valid (out_valid),
    .filled    (filled),
    .fill_cnt  (fill_cnt)
  );

  always #5 clk = ~clk;

`ifdef MOVING_AVERAGE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one strobe for a single edge, then idle one edge; check the output pulse
  task automatic strobe_gap(input logic [7:0] d, input logic [7:0] exp_avg, input string tag);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    check({tag, "_ov_lat"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check({tag, "_avg"}, 32'(avg_out), 32'(exp_avg));
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;

    // 1 Reset
    tick(); tick();
    check("rst_avg",  32'(avg_out),   32'd0);
    check("rst_ov",   32'(out_valid), 32'd0);
    check("rst_fill", 32'(filled),    32'd0);
    check("rst_cnt",  32'(fill_cnt),  32'd0);
    rst_n = 1'b1;
    tick();

    // 2 Warm-up and eviction
    strobe_gap(8'hAA, RND ? 8'h2B : 8'h2A, "s2_aa");
    strobe_gap(8'h55, RND ? 8'h40 : 8'h3F, "s2_55");
    strobe_gap(8'hFF, RND ? 8'h80 : 8'h7F, "s2_ff");
    check("s2_notfilled", 32'(filled), 32'd0);
    strobe_gap(8'h00, RND ? 8'h80 : 8'h7F, "s2_00");
    check("s2_filled", 32'(filled),   32'd1);
    check("s2_cnt4",   32'(fill_cnt), 32'd4);
    strobe_gap(8'hFF, RND ? 8'h95 : 8'h94, "s2_evict");
    check("s2_cnt_sat", 32'(fill_cnt), 32'd4);

    // 3 Back-to-back strobes
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    check("s3_ov0", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s3_ov_b2b", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("s3_ov_last", 32'(out_valid), 32'd1);
    check("s3_avg",     32'(avg_out),   32'hFF);
    tick();
    check("s3_ov_idle", 32'(out_valid), 32'd0);

    // 4 Clear wins over same-cycle strobe
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("s4_cnt",    32'(fill_cnt),  32'd0);
    check("s4_filled", 32'(filled),    32'd0);
    check("s4_ov",     32'(out_valid), 32'd0);
    tick();
    check("s4_ov_next", 32'(out_valid), 32'd0);
    check("s4_avg_hold", 32'(avg_out),  32'hFF);
    strobe_gap(8'h40, 8'h10, "s4_40");
    check("s4_cnt1", 32'(fill_cnt), 32'd1);

    // 5 Enable gating
    ena = 1'b0; in_valid = 1'b1; in_data = 8'h80;
    tick();
    in_valid = 1'b0;
    check("s5_cnt_hold", 32'(fill_cnt), 32'd1);
    tick();
    check("s5_no_ov", 32'(out_valid), 32'd0);
    ena = 1'b1;
    strobe_gap(8'h80, 8'h30, "s5_80");
    check("s5_cnt2", 32'(fill_cnt), 32'd2);

    // 6 Reset with a sample in flight
    in_valid = 1'b1; in_data = 8'hC0;
    tick();
    in_valid = 1'b0;
    check("s6_cnt3", 32'(fill_cnt), 32'd3);
    rst_n = 1'b0;
    #1;
    check("s6_async_avg", 32'(avg_out),   32'd0);
    check("s6_async_cnt", 32'(fill_cnt),  32'd0);
    check("s6_async_fil", 32'(filled),    32'd0);
    tick();
    check("s6_no_ov", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("s6_no_ov2", 32'(out_valid), 32'd0);
    check("s6_avg0",   32'(avg_out),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
